// File: rtl/epx_exp_share_arbiter.sv
// ---------------------------------------------------------------------------
// epx_exp_share_arbiter
// Shares one e^x lookup unit between N_REQ requesters.
//   - Round-robin arbiter, one issue per cycle, guarded by a credit counter
//     that covers inflight operations plus response FIFO occupancy.
//   - A tag pipe ({valid, id, err}) runs alongside the exp unit so each
//     result is paired with its requester when it comes back.
//   - Results land in an in-order response FIFO with valid/ready output.
//   - Operands the LUT cannot represent (anything other than 0 or integer
//     +-1..+-31) are still issued but return rsp_err=1 with data 0.
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   req_valid/req_data  per-requester operand (slice i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready           one-hot grant
//   exp_valid_in/exp_in registered issue to the exp unit
//   exp_valid_out/exp_out result from the exp unit
//   rsp_valid/rsp_ready FIFO head handshake
//   rsp_data/rsp_id/rsp_err  FIFO head contents
//   proto_err           sticky: result returned with no matching tag
// ---------------------------------------------------------------------------
module epx_exp_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int EXP_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        exp_valid_in,
    output logic [DATA_WIDTH-1:0]       exp_in,
    input  logic                        exp_valid_out,
    input  logic [DATA_WIDTH-1:0]       exp_out,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        rsp_err,
    output logic                        proto_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // LUT covers 0 and integers +-1..+-31: biased exponent 127..131 with
    // every mantissa bit below the binary point clear.
    function automatic logic op_unsupported(input logic [DATA_WIDTH-1:0] x);
        logic [7:0]  e;
        logic [22:0] m;
        logic [22:0] mask;
        e = x[30:23];
        m = x[22:0];
        if (x == '0) return 1'b0;
        if (e < 8'd127 || e > 8'd131) return 1'b1;
        mask = 23'h7F_FFFF >> (e - 8'd127);
        return |(m & mask);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]            r_cnt;      // inflight + queued
    logic [ID_W-1:0]             r_rr;       // highest-priority requester
    logic                        r_evi;
    logic [DATA_WIDTH-1:0]       r_ein;
    logic [EXP_LAT:0]            r_tag_vld;
    logic [EXP_LAT:0][ID_W-1:0]  r_tag_id;
    logic [EXP_LAT:0]            r_tag_err;
    logic                        r_proto;

    logic [DATA_WIDTH-1:0]       r_mem_data [FIFO_DEPTH];
    logic [ID_W-1:0]             r_mem_id   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]       r_mem_err;
    logic [PTR_W-1:0]            r_wptr;
    logic [PTR_W-1:0]            r_rptr;
    logic [CNT_W-1:0]            r_fcnt;

    logic                        w_credit;
    logic                        w_hs;
    logic [ID_W-1:0]             w_gid;
    logic [N_REQ-1:0]            w_grant;
    logic [DATA_WIDTH-1:0]       w_op;
    logic                        w_err;
    logic                        w_cap;
    logic                        w_orphan;
    logic                        w_pop;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_credit = (r_cnt < CNT_W'(FIFO_DEPTH));

    always_comb begin
        w_hs  = 1'b0;
        w_gid = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_credit && !w_hs && req_valid[rr_idx(r_rr, k)]) begin
                w_hs  = 1'b1;
                w_gid = rr_idx(r_rr, k);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_hs) w_grant[w_gid] = 1'b1;
    end

    assign req_ready = w_grant;

    always_comb begin
        w_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gid == ID_W'(i)) w_op = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_err = op_unsupported(w_op);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr <= '0;
        end else if (w_hs) begin
            r_rr <= rr_idx(w_gid, 1);
        end
    end

    // ------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_evi <= 1'b0;
            r_ein <= '0;
        end else begin
            r_evi <= w_hs;
            if (w_hs) r_ein <= w_op;
        end
    end

    assign exp_valid_in = r_evi;
    assign exp_in       = r_ein;

    // ------------------------------------------------------------------
    // Tag pipe. Stage 0 loads alongside the issue register, so the pipe is
    // one stage longer than the unit latency; stage EXP_LAT lines up with
    // exp_valid_out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
            r_tag_err <= '0;
        end else begin
            r_tag_vld[0] <= w_hs;
            r_tag_id[0]  <= w_gid;
            r_tag_err[0] <= w_err;
            for (int s = 1; s <= EXP_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
                r_tag_err[s] <= r_tag_err[s-1];
            end
        end
    end

    assign w_cap    = exp_valid_out &  r_tag_vld[EXP_LAT];
    assign w_orphan = exp_valid_out & ~r_tag_vld[EXP_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_proto <= 1'b0;
        else if (w_orphan) r_proto <= 1'b1;
    end

    assign proto_err = r_proto;

    // ------------------------------------------------------------------
    // Response FIFO. Credits keep it from overflowing, so capture never
    // checks for full; write+read in one cycle is fine at any occupancy.
    // ------------------------------------------------------------------
    assign w_pop = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_fcnt    <= '0;
            r_mem_err <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_id[i]   <= '0;
            end
        end else begin
            if (w_cap) begin
                r_mem_data[r_wptr] <= r_tag_err[EXP_LAT] ? '0 : exp_out;
                r_mem_id[r_wptr]   <= r_tag_id[EXP_LAT];
                r_mem_err[r_wptr]  <= r_tag_err[EXP_LAT];
                r_wptr             <= r_wptr + PTR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_cap, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
                2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    assign rsp_valid = (r_fcnt != '0);
    assign rsp_data  = r_mem_data[r_rptr];
    assign rsp_id    = r_mem_id[r_rptr];
    assign rsp_err   = r_mem_err[r_rptr];

    // ------------------------------------------------------------------
    // Credit counter. A pop frees its credit only from the next cycle on,
    // since w_credit looks at the registered count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            case ({w_hs, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
